// File: rtl/qr_array_scheduler_if.sv
// Handshake and data bundle between the QR array scheduler and its environment.
// The master side drives control and the load stream; the slave side is the scheduler.
interface qr_array_scheduler_if #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 20
);
  logic                           start_i;
  logic                           abort_i;
  logic                           in_valid_i;
  logic                           in_ready_o;
  logic signed [DATA_WIDTH-1:0]   in_data_i;
  logic        [N*DATA_WIDTH-1:0] a_o;
  logic        [N-1:0]            valid_o;
  logic                           rotates_o;
  logic                           clr_o;
  logic                           busy_o;
  logic                           done_o;

  modport master (
    output start_i, abort_i, in_valid_i, in_data_i,
    input  in_ready_o, a_o, valid_o, rotates_o, clr_o, busy_o, done_o
  );

  modport slave (
    input  start_i, abort_i, in_valid_i, in_data_i,
    output in_ready_o, a_o, valid_o, rotates_o, clr_o, busy_o, done_o
  );
endinterface

// File: rtl/qr_array_scheduler.sv
// Sequences one N x N QR decomposition through the systolic Givens-rotation array:
// buffers the matrix from a valid/ready stream, injects rows into the array columns
// with a one-slot skew per column, and drives the array-wide clear/rotate controls.
module qr_array_scheduler #(
  parameter int N            = 4,
  parameter int DATA_WIDTH   = 20,
  parameter int SLOT         = 4,
  parameter int DRAIN_CYCLES = 32
) (
  input logic               clk,
  input logic               rst_n,
  qr_array_scheduler_if.slave bus
);

  localparam int DEPTH   = N * N;
  localparam int RUN_LEN = (2 * N - 1) * SLOT;
  localparam int WPTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RUN_W   = (RUN_LEN > 1) ? $clog2(RUN_LEN) : 1;
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  localparam logic [WPTR_W-1:0]  WPTR_LAST  = WPTR_W'(DEPTH - 1);
  localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(RUN_LEN - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [WPTR_W-1:0]  wptr;
  logic [RUN_W-1:0]   run_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               abort_clr;

  logic signed [DATA_WIDTH-1:0] buf_mem [DEPTH];

  logic              abort_hit;
  logic              accept;
  int                slot_idx;
  int                phase;
  int                row;
  logic [WPTR_W-1:0] rd_idx;

  // Abort only matters outside IDLE and always beats a pending stream accept.
  assign abort_hit = bus.abort_i && (state != IDLE);
  assign accept    = (state == LOAD) && bus.in_valid_i && !bus.abort_i;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; abort overrides every other transition.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start_i) state_next = CLEAR;
      CLEAR:   state_next = LOAD;
      LOAD:    if (accept && (wptr == WPTR_LAST)) state_next = RUN;
      RUN:     if (run_cnt == RUN_LAST) state_next = DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort_hit) begin
      state_next = IDLE;
    end
  end

  // Write pointer, RUN/DRAIN cycle counters and the post-abort clear flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      run_cnt   <= '0;
      drain_cnt <= '0;
      abort_clr <= 1'b0;
    end else begin
      abort_clr <= abort_hit;
      if (abort_hit) begin
        wptr      <= '0;
        run_cnt   <= '0;
        drain_cnt <= '0;
      end else begin
        if (accept) begin
          wptr <= (wptr == WPTR_LAST) ? '0 : wptr + 1'b1;
        end
        if (state == RUN) begin
          run_cnt <= (run_cnt == RUN_LAST) ? '0 : run_cnt + 1'b1;
        end else begin
          run_cnt <= '0;
        end
        if (state == DRAIN) begin
          drain_cnt <= (drain_cnt == DRAIN_LAST) ? '0 : drain_cnt + 1'b1;
        end else begin
          drain_cnt <= '0;
        end
      end
    end
  end

  // Matrix buffer; contents survive reset and are simply overwritten by the next load.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_mem[wptr] <= bus.in_data_i;
    end
  end

  // Output decode: column c injects row (slot - c) on the first cycle of each slot.
  always_comb begin
    bus.in_ready_o = (state == LOAD);
    bus.clr_o      = (state == CLEAR) || abort_clr;
    bus.rotates_o  = (state == RUN) || (state == DRAIN);
    bus.busy_o     = (state != IDLE);
    bus.done_o     = (state == DONE);
    bus.valid_o    = '0;
    bus.a_o        = '0;
    slot_idx       = int'(run_cnt) / SLOT;
    phase          = int'(run_cnt) % SLOT;
    row            = 0;
    rd_idx         = '0;
    if ((state == RUN) && (phase == 0)) begin
      for (int c = 0; c < N; c++) begin
        row = slot_idx - c;
        if ((row >= 0) && (row < N)) begin
          rd_idx                                  = WPTR_W'(row * N + c);
          bus.valid_o[c]                          = 1'b1;
          bus.a_o[c*DATA_WIDTH +: DATA_WIDTH]     = buf_mem[rd_idx];
        end
      end
    end
  end

endmodule
